// File: rtl/stream_mux_arbiter_if.sv
// Stream bundle for stream_mux_arbiter: selection controls, N input
// channels with valid/ready, and the single registered output stream.
interface stream_mux_arbiter_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic                      mode;
    logic [SEL_W-1:0]          address;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_channel;

    // Producer/consumer side that drives the arbiter.
    modport master (
        output mode, address, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_channel
    );

    // Arbiter side.
    modport slave (
        input  mode, address, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_channel
    );
endinterface

// File: rtl/stream_mux_arbiter.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Channel choice is either by external address (mode=0) or round-robin
// among valid channels (mode=1). Data is always registered before output.
module stream_mux_arbiter #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    stream_mux_arbiter_if.slave bus
);
    localparam int               VEXT_W   = 2 ** SEL_W;
    localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(CHANNELS - 32'sd1);

    logic [WIDTH-1:0]    out_data_r;
    logic                out_valid_r;
    logic [SEL_W-1:0]    out_channel_r;
    logic [SEL_W-1:0]    last_r;

    logic                load_en_s;
    logic [VEXT_W-1:0]   valid_ext_s;
    logic                a_found_s;
    logic                rr_found_s;
    logic [SEL_W-1:0]    rr_idx_s;
    int                  rr_cand_s;
    logic [SEL_W-1:0]    rr_pos_s;
    logic                grant_found_s;
    logic [SEL_W-1:0]    grant_idx_s;
    logic                go_s;
    logic [CHANNELS-1:0] in_ready_s;
    logic [WIDTH-1:0]    sel_data_s;

    // Register may load when empty or when its word is drained this cycle.
    assign load_en_s   = !out_valid_r | bus.out_ready;
    // Zero-extend valids so any SEL_W-wide index is in range.
    assign valid_ext_s = VEXT_W'(bus.in_valid);

    // Addressed grant: out-of-range addresses never grant.
    always_comb begin
        a_found_s = 1'b0;
        if (({1'b0, bus.address} < CH_LIM) && valid_ext_s[bus.address]) begin
            a_found_s = 1'b1;
        end else begin
            a_found_s = 1'b0;
        end
    end

    // Round-robin grant: first valid channel after the last winner, wrapping.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = '0;
        rr_cand_s  = 32'sd0;
        rr_pos_s   = '0;
        for (int k = 32'sd1; k <= CHANNELS; k++) begin
            rr_cand_s = int'(last_r) + k;
            if (rr_cand_s >= CHANNELS) begin
                rr_cand_s = rr_cand_s - CHANNELS;
            end else begin
                rr_cand_s = rr_cand_s;
            end
            rr_pos_s = rr_cand_s[SEL_W-1:0];
            if (!rr_found_s && valid_ext_s[rr_pos_s]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = rr_pos_s;
            end else begin
                rr_found_s = rr_found_s;
                rr_idx_s   = rr_idx_s;
            end
        end
    end

    // Pick the grant source according to the selection mode.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        case (bus.mode)
            1'b0: begin
                grant_found_s = a_found_s;
                grant_idx_s   = bus.address;
            end
            1'b1: begin
                grant_found_s = rr_found_s;
                grant_idx_s   = rr_idx_s;
            end
            default: begin
                grant_found_s = 1'b0;
                grant_idx_s   = '0;
            end
        endcase
    end

    // A grant always implies in_valid, so go_s is exactly the transfer strobe.
    assign go_s = grant_found_s & load_en_s & !reset;

    // One-hot ready and data select for the granted channel.
    always_comb begin
        in_ready_s = '0;
        sel_data_s = '0;
        for (int i = 32'sd0; i < CHANNELS; i++) begin
            if (grant_idx_s == i[SEL_W-1:0]) begin
                in_ready_s[i] = go_s;
                sel_data_s    = bus.in_data[i*WIDTH +: WIDTH];
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    // Output register and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_r    <= '0;
            out_valid_r   <= 1'b0;
            out_channel_r <= '0;
            last_r        <= LAST_RST;
        end else if (go_s) begin
            out_data_r    <= sel_data_s;
            out_valid_r   <= 1'b1;
            out_channel_r <= grant_idx_s;
            if (bus.mode) begin
                last_r <= grant_idx_s;
            end
        end else if (bus.out_ready && out_valid_r) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_data    = out_data_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_channel = out_channel_r;
endmodule

// File: tb/tb_stream_mux_arbiter.sv
// Directed self-checking bench for stream_mux_arbiter: a 4-channel and a
// 3-channel instance sharing clock and reset.
module tb_stream_mux_arbiter;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    stream_mux_arbiter_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) b4 ();
    stream_mux_arbiter_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) b3 ();

    stream_mux_arbiter #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut4 (
        .clk(clk), .reset(reset), .bus(b4)
    );
    stream_mux_arbiter #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset(reset), .bus(b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        b4.mode = 1'b1; b4.address = 2'd0; b4.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
        b3.mode = 1'b0; b3.address = 2'd0; b3.in_data = 24'h0;
        b3.in_valid = 3'b000; b3.out_ready = 1'b1;
        tick(); tick();
        total++; if (b4.in_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b exp=0000", b4.in_ready); end
        total++; if (b4.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", b4.out_valid); end
        total++; if (b4.out_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", b4.out_data); end
        total++; if (b4.out_channel !== 2'd0) begin bad++; $display("FAIL rst_chan got=%0d exp=0", b4.out_channel); end
        b4.in_valid = 4'b0000;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_addressed();
        b4.mode = 1'b0; b4.address = 2'd2; b4.in_valid = 4'b0100;
        b4.in_data = {8'h00, 8'hA5, 8'h00, 8'h00}; b4.out_ready = 1'b1;
        #1;
        total++; if (b4.in_ready !== 4'b0100) begin bad++; $display("FAIL addr_ready got=%b exp=0100", b4.in_ready); end
        tick();
        b4.in_valid = 4'b0000;
        total++; if (b4.out_data !== 8'hA5) begin bad++; $display("FAIL addr_data got=%h exp=a5", b4.out_data); end
        total++; if (b4.out_valid !== 1'b1) begin bad++; $display("FAIL addr_valid got=%b exp=1", b4.out_valid); end
        total++; if (b4.out_channel !== 2'd2) begin bad++; $display("FAIL addr_chan got=%0d exp=2", b4.out_channel); end
        tick();
        total++; if (b4.out_valid !== 1'b0) begin bad++; $display("FAIL addr_drain got=%b exp=0", b4.out_valid); end
        total++; if (b4.out_data !== 8'hA5) begin bad++; $display("FAIL addr_hold got=%h exp=a5", b4.out_data); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [5];
        logic [1:0] exp_c [5];
        exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        exp_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        b4.mode = 1'b1; b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
        b4.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int n = 0; n < 5; n++) begin
            tick();
            total++; if (b4.out_data !== exp_d[n] || b4.out_channel !== exp_c[n] || b4.out_valid !== 1'b1)
                begin bad++; $display("FAIL rr_seq%0d got=%h/%0d/%b exp=%h/%0d/1", n, b4.out_data, b4.out_channel, b4.out_valid, exp_d[n], exp_c[n]); end
        end
        b4.in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_alternate();
        logic [1:0] exp_c [4];
        exp_c = '{2'd1, 2'd3, 2'd1, 2'd3};
        b4.mode = 1'b1; b4.in_valid = 4'b1010; b4.out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            total++; if (b4.out_channel !== exp_c[n] || b4.out_valid !== 1'b1 || b4.out_data !== (8'h10 + 8'(exp_c[n])))
                begin bad++; $display("FAIL alt%0d got=%0d/%b/%h exp=%0d/1", n, b4.out_channel, b4.out_valid, b4.out_data, exp_c[n]); end
        end
        b4.in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        b4.mode = 1'b0; b4.address = 2'd0; b4.in_valid = 4'b0001;
        b4.in_data = {8'h00, 8'h00, 8'h00, 8'h3C}; b4.out_ready = 1'b1;
        tick();
        total++; if (b4.out_data !== 8'h3C || b4.out_valid !== 1'b1) begin bad++; $display("FAIL bp_load got=%h/%b exp=3c/1", b4.out_data, b4.out_valid); end
        b4.in_data = {8'h00, 8'h00, 8'h00, 8'h5A}; b4.out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1;
            total++; if (b4.in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready%0d got=%b exp=0000", n, b4.in_ready); end
            tick();
            total++; if (b4.out_data !== 8'h3C || b4.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got=%h/%b exp=3c/1", n, b4.out_data, b4.out_valid); end
        end
        b4.out_ready = 1'b1;
        #1;
        total++; if (b4.in_ready !== 4'b0001) begin bad++; $display("FAIL bp_release got=%b exp=0001", b4.in_ready); end
        tick();
        total++; if (b4.out_data !== 8'h5A || b4.out_valid !== 1'b1) begin bad++; $display("FAIL bp_reload got=%h/%b exp=5a/1", b4.out_data, b4.out_valid); end
        b4.in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_out_of_range();
        logic [1:0] exp_c [4];
        exp_c = '{2'd0, 2'd1, 2'd2, 2'd0};
        b3.mode = 1'b0; b3.address = 2'd3; b3.in_valid = 3'b111;
        b3.in_data = {8'h22, 8'h21, 8'h20}; b3.out_ready = 1'b1;
        #1;
        total++; if (b3.in_ready !== 3'b000) begin bad++; $display("FAIL oor_ready got=%b exp=000", b3.in_ready); end
        tick(); tick();
        total++; if (b3.out_valid !== 1'b0) begin bad++; $display("FAIL oor_valid got=%b exp=0", b3.out_valid); end
        b3.address = 2'd1;
        #1;
        total++; if (b3.in_ready !== 3'b010) begin bad++; $display("FAIL oor_switch got=%b exp=010", b3.in_ready); end
        tick();
        total++; if (b3.out_data !== 8'h21 || b3.out_channel !== 2'd1 || b3.out_valid !== 1'b1)
            begin bad++; $display("FAIL oor_load got=%h/%0d/%b exp=21/1/1", b3.out_data, b3.out_channel, b3.out_valid); end
        b3.mode = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            total++; if (b3.out_channel !== exp_c[n] || b3.out_data !== (8'h20 + 8'(exp_c[n])))
                begin bad++; $display("FAIL rr3_wrap%0d got=%0d/%h exp=%0d", n, b3.out_channel, b3.out_data, exp_c[n]); end
        end
        b3.in_valid = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid();
        b4.mode = 1'b1; b4.in_valid = 4'b0100; b4.out_ready = 1'b1;
        b4.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        tick();
        total++; if (b4.out_channel !== 2'd2 || b4.out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0d/%b exp=2/1", b4.out_channel, b4.out_valid); end
        b4.out_ready = 1'b0; b4.in_valid = 4'b1111;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (b4.out_valid !== 1'b0 || b4.out_data !== 8'h00) begin bad++; $display("FAIL mid_rst got=%b/%h exp=0/00", b4.out_valid, b4.out_data); end
        b4.out_ready = 1'b1;
        tick();
        total++; if (b4.out_channel !== 2'd0 || b4.out_data !== 8'h10) begin bad++; $display("FAIL mid_first got=%0d/%h exp=0/10", b4.out_channel, b4.out_data); end
        tick();
        total++; if (b4.out_channel !== 2'd1 || b4.out_data !== 8'h11) begin bad++; $display("FAIL mid_second got=%0d/%h exp=1/11", b4.out_channel, b4.out_data); end
        b4.in_valid = 4'b0000;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        test_reset();
        test_addressed();
        test_round_robin();
        test_alternate();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
